// File: rtl/c1541_pkg.sv
// rtl/c1541_pkg.sv - shared types and constants for the c1541 SD channel arbiter
package c1541_pkg;

  localparam int SD_LBA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/c1541_rr_pick.sv
// rtl/c1541_rr_pick.sv - combinational round-robin first-set finder
module c1541_rr_pick #(
  parameter int NDRV = 4
) (
  input  logic [NDRV-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      gnt_idx,
  output logic            any
);

  // Scan offsets from farthest to nearest so the nearest set bit at or after ptr wins.
  always_comb begin
    gnt_idx = 2'd0;
    for (int k = NDRV - 1; k >= 0; k--) begin
      for (int c = 0; c < NDRV; c++) begin
        if (req[c] && (c == ((int'(ptr) + k) % NDRV))) begin
          gnt_idx = 2'(c);
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/c1541_sd_arbiter.sv
// rtl/c1541_sd_arbiter.sv - round-robin share of one SD block channel among NDRV drives (watchdog: SD_ARB_TIMEOUT_EN)
module c1541_sd_arbiter
  import c1541_pkg::*;
#(
  parameter int NDRV    = 4,
  parameter int TIMEOUT = 2**24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [NDRV*32-1:0]     drv_lba,
  input  logic [NDRV-1:0]        drv_rd,
  input  logic [NDRV-1:0]        drv_wr,
  output logic [NDRV-1:0]        drv_ack,
  input  logic [NDRV*8-1:0]      drv_buff_din,
  output logic [NDRV-1:0]        drv_buff_wr,
  output logic [SD_LBA_W-1:0]    sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [SD_LBA_W-1:0]   lba_q, lba_d;
  logic                  sd_rd_q, sd_rd_d;
  logic                  sd_wr_q, sd_wr_d;
  logic [NDRV-1:0]       drv_ack_q, drv_ack_d;
  logic                  timeout_err_q, timeout_err_d;

  logic [1:0]            pick_idx;
  logic                  pick_any;
  logic [SD_LBA_W-1:0]   pick_lba;
  logic                  pick_wr;
  logic                  g_rd, g_wr;
  logic [7:0]            g_din;
  logic                  req_live;
  logic [1:0]            ptr_next;

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);
  logic [23:0]           cnt_q, cnt_d;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic                  unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  c1541_rr_pick #(.NDRV(NDRV)) u_pick (
    .req     (drv_rd | drv_wr),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Per-drive field selection for the candidate in IDLE and for the latched grant.
  always_comb begin
    pick_lba = '0;
    pick_wr  = 1'b0;
    g_rd     = 1'b0;
    g_wr     = 1'b0;
    g_din    = 8'd0;
    for (int i = 0; i < NDRV; i++) begin
      if (2'(i) == pick_idx) begin
        pick_lba = drv_lba[32*i +: 32];
        pick_wr  = drv_wr[i];
      end
      if (2'(i) == grant_q) begin
        g_rd  = drv_rd[i];
        g_wr  = drv_wr[i];
        g_din = drv_buff_din[8*i +: 8];
      end
    end
  end

  // The request that earned the grant must stay up until the host acks.
  assign req_live = (op_q == OP_WR) ? g_wr : g_rd;
  assign ptr_next = (grant_q == 2'(NDRV - 1)) ? 2'd0 : grant_q + 2'd1;

  // Next-state and registered-output logic for the IDLE/REQ/XFER/REL sequence.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    lba_d         = lba_q;
    sd_rd_d       = sd_rd_q;
    sd_wr_d       = sd_wr_q;
    drv_ack_d     = drv_ack_q;
    timeout_err_d = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          lba_d   = pick_lba;
          op_d    = pick_wr ? OP_WR : OP_RD;
          sd_wr_d = pick_wr;
          sd_rd_d = ~pick_wr;
          state_d = ST_REQ;
`ifdef SD_ARB_TIMEOUT_EN
          cnt_d   = 24'd0;
`endif
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          sd_rd_d   = 1'b0;
          sd_wr_d   = 1'b0;
          drv_ack_d = '0;
          for (int i = 0; i < NDRV; i++) begin
            if (2'(i) == grant_q) drv_ack_d[i] = 1'b1;
          end
          state_d   = ST_XFER;
        end else if (!req_live) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_IDLE;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          sd_rd_d       = 1'b0;
          sd_wr_d       = 1'b0;
          timeout_err_d = 1'b1;
          rr_ptr_d      = ptr_next;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end
      ST_XFER: begin
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
        if (!sd_ack) begin
          drv_ack_d = '0;
          rr_ptr_d  = ptr_next;
          state_d   = ST_REL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every strobe and ack immediately.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_RD;
      grant_q       <= 2'd0;
      rr_ptr_q      <= 2'd0;
      lba_q         <= '0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      drv_ack_q     <= '0;
      timeout_err_q <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q         <= 24'd0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      lba_q         <= lba_d;
      sd_rd_q       <= sd_rd_d;
      sd_wr_q       <= sd_wr_d;
      drv_ack_q     <= drv_ack_d;
      timeout_err_q <= timeout_err_d;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  // Buffer strobes reach only the granted drive, and only while data is moving.
  always_comb begin
    drv_buff_wr = '0;
    for (int i = 0; i < NDRV; i++) begin
      drv_buff_wr[i] = (state_q == ST_XFER) && (2'(i) == grant_q) && sd_buff_wr;
    end
  end

  assign sd_buff_din = (state_q == ST_XFER) ? g_din : 8'd0;
  assign sd_lba      = lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign drv_ack     = drv_ack_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
`ifdef SD_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// tb/tb_c1541_sd_arbiter.sv - self-checking bench for c1541_sd_arbiter
module tb_c1541_sd_arbiter;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic [127:0] drv_lba;
  logic [3:0]   drv_rd, drv_wr, drv_ack, drv_buff_wr;
  logic [31:0]  drv_buff_din;
  logic [31:0]  sd_lba;
  logic         sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]   sd_buff_din;
  logic [1:0]   grant_id;
  logic         busy, timeout_err;

  logic [31:0]  lba_tab [4];
  logic [31:0]  lba_in  [4];
  logic [7:0]   din_in  [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] g;
    logic       wr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] rd;
    logic [3:0] wr;
    logic [1:0] g;
    logic       wr_op;
  } vec_t;
  vec_t tab [8];

  always #5 clk_sys = ~clk_sys;

  always_comb begin
    drv_lba      = '0;
    drv_buff_din = '0;
    for (int i = 0; i < 4; i++) begin
      drv_lba[32*i +: 32]     = lba_in[i];
      drv_buff_din[8*i +: 8]  = din_in[i];
    end
  end

  c1541_sd_arbiter #(.NDRV(4), .TIMEOUT(16)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .drv_buff_wr  (drv_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sd_rd || sd_wr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    if (!ok) chk("strobe_wait", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    drv_rd = 4'b0; drv_wr = 4'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  // One full grant: check the strobe against the scoreboard, ack, and drop the served request.
  task automatic serve();
    exp_t e;
    bit   ok;
    wait_strobe(ok);
    if (!ok) return;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("grant_id", {30'd0, grant_id}, {30'd0, e.g});
    chk("sd_wr", {31'd0, sd_wr}, {31'd0, e.wr});
    chk("sd_rd", {31'd0, sd_rd}, {31'd0, ~e.wr});
    chk("sd_lba", sd_lba, lba_tab[e.g]);
    lba_in[e.g] = ~lba_tab[e.g];
    @(negedge clk_sys);
    chk("sd_lba_hold", sd_lba, lba_tab[e.g]);
    lba_in[e.g] = lba_tab[e.g];
    sd_ack = 1'b1;
    @(negedge clk_sys);
    chk("drv_ack", {28'd0, drv_ack}, {28'd0, 4'b0001 << e.g});
    chk("strobe_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
    if (e.wr) drv_wr[e.g] = 1'b0;
    else      drv_rd[e.g] = 1'b0;
    sd_ack = 1'b0;
    @(negedge clk_sys);
    chk("drv_ack_rel", {28'd0, drv_ack}, 32'd0);
    chk("busy_rel", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_idle(input string name);
    drv_rd = 4'b0; drv_wr = 4'b0;
    @(negedge clk_sys);
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit   ok;
    int   n;
    bit   seen;

    lba_tab[0] = 32'hA000_0000; lba_tab[1] = 32'h0000_0123;
    lba_tab[2] = 32'h00C0_FFEE; lba_tab[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      lba_in[i] = lba_tab[i];
      din_in[i] = 8'h00;
    end

    //            rd       wr       g     wr_op   (pointer walks 0->2->1->0->2->3->1->3->1)
    tab[0] = '{4'b0010, 4'b0000, 2'd1, 1'b0};
    tab[1] = '{4'b0001, 4'b0000, 2'd0, 1'b0};
    tab[2] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tab[3] = '{4'b0110, 4'b0000, 2'd1, 1'b0};
    tab[4] = '{4'b0101, 4'b0000, 2'd2, 1'b0};
    tab[5] = '{4'b0001, 4'b0100, 2'd0, 1'b0};
    tab[6] = '{4'b0000, 4'b1100, 2'd2, 1'b1};
    tab[7] = '{4'b0011, 4'b0000, 2'd0, 1'b0};

    drv_rd = 4'b0; drv_wr = 4'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_strobes", {30'd0, sd_rd, sd_wr}, 32'd0);
    chk("rst_ack", {28'd0, drv_ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{tab[i].g, tab[i].wr_op});
      drv_rd = tab[i].rd;
      drv_wr = tab[i].wr;
      @(negedge clk_sys);
      chk("latency1", {31'd0, sd_rd | sd_wr}, 32'd1);
      serve();
      finish_idle("tab_idle");
    end

    // Write then read from the same drive (pointer is 1)
    sb.push_back('{2'd3, 1'b1});
    sb.push_back('{2'd3, 1'b0});
    drv_rd = 4'b1000; drv_wr = 4'b1000;
    serve();
    serve();
    finish_idle("wr_rd_idle");

    // Contention: all four read at once from pointer 0
    do_reset();
    for (int i = 0; i < 4; i++) sb.push_back('{2'(i), 1'b0});
    drv_rd = 4'b1111;
    for (int i = 0; i < 4; i++) serve();
    finish_idle("cont_idle");
    chk("sb_drained", sb.size(), 32'd0);

    // Write data path on drive 2 (pointer is 0)
    drv_wr = 4'b0100;
    wait_strobe(ok);
    chk("wdp_grant", {30'd0, grant_id}, 32'd2);
    chk("wdp_sd_wr", {31'd0, sd_wr}, 32'd1);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    drv_wr = 4'b0000;
    seen = 1'b0;
    for (int a = 0; a < 512; a++) begin
      din_in[2] = 8'(a) ^ 8'h5A;
      din_in[0] = 8'($urandom); din_in[1] = 8'($urandom); din_in[3] = 8'($urandom);
      sd_buff_wr = 1'b1;
      #1;
      if (sd_buff_din !== (8'(a) ^ 8'h5A) || drv_buff_wr !== 4'b0100) begin
        if (!seen) begin
          chk("wdp_din", {24'd0, sd_buff_din}, {24'd0, 8'(a) ^ 8'h5A});
          chk("wdp_bwr", {28'd0, drv_buff_wr}, 32'h4);
        end
        seen = 1'b1;
      end
      sd_buff_wr = 1'b0;
      @(negedge clk_sys);
    end
    chk("wdp_all_pulses", {31'd0, seen}, 32'd0);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    sd_buff_wr = 1'b1; #1;
    chk("bwr_in_rel", {28'd0, drv_buff_wr}, 32'd0);
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    sd_buff_wr = 1'b1; #1;
    chk("bwr_in_idle", {28'd0, drv_buff_wr}, 32'd0);
    chk("din_in_idle", {24'd0, sd_buff_din}, 32'd0);
    sd_buff_wr = 1'b0;

    // Fairness: drive 0 re-requests right after REL while drive 3 waits
    do_reset();
    sb.push_back('{2'd0, 1'b0});
    sb.push_back('{2'd3, 1'b0});
    sb.push_back('{2'd0, 1'b0});
    drv_rd = 4'b1001;
    serve();
    drv_rd[0] = 1'b1;
    serve();
    serve();
    finish_idle("fair_idle");

    // Abort during REQ leaves the pointer at 0
    do_reset();
    drv_rd = 4'b0010;
    @(negedge clk_sys);
    chk("abort_rd_up", {31'd0, sd_rd}, 32'd1);
    drv_rd = 4'b0000;
    @(negedge clk_sys);
    chk("abort_rd_down", {31'd0, sd_rd}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    sb.push_back('{2'd1, 1'b0});
    drv_rd = 4'b0110;
    serve();
    finish_idle("abort_idle");

    // Reset asserted in XFER drops everything before the next edge
    drv_rd = 4'b0001;
    wait_strobe(ok);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    chk("xfer_ack", {28'd0, drv_ack}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_strobes", {30'd0, sd_rd, sd_wr}, 32'd0);
    chk("async_ack", {28'd0, drv_ack}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    drv_rd = 4'b0; sd_ack = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    // Watchdog
    drv_rd = 4'b0100;
    wait_strobe(ok);
    n = 0;
`ifdef SD_ARB_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      n++;
      if (timeout_err) break;
    end
    chk("timeout_cycles", n, 32'd16);
    chk("timeout_rd_drop", {31'd0, sd_rd}, 32'd0);
    drv_rd = 4'b0000;
    @(negedge clk_sys);
    chk("timeout_pulse", {31'd0, timeout_err}, 32'd0);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (timeout_err || !sd_rd) seen = 1'b1;
    end
    chk("no_watchdog_wait", {31'd0, seen}, 32'd0);
    drv_rd = 4'b0000;
    @(negedge clk_sys);
    chk("no_watchdog_abort", {31'd0, busy}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
